pipe_scroller: RTL and testbench
================================

Name: pipe_scroller

Overview:
- Produces the pipe position (pipe_x, pipe_y) consumed by the collision detector, so it is the producer end of that interface.
- Scrolls one pipe leftward once per video frame and respawns it off-screen right with a pseudo-random gap centre.
- Counts pipes passed, and freezes all motion when a collision is reported.
- Sits between the VGA frame timing and the collision/graphics blocks.

Parameters:
- SPEED, 2: pixels pipe_x decrements per frame tick.
- SPAWN_X, 700: pipe_x value after reset, idle and respawn (off-screen right).
- SCORE_X, 264: pipe counts as passed when pipe_x crosses from above SCORE_X to at-or-below it.
- GAP_Y_MIN, 120: minimum gap centre; pipe_y = GAP_Y_MIN + 8-bit LFSR value (range 120..375).
- IDLE_Y, 240: pipe_y held in IDLE.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-high reset.
- frame_clk, input, 1: frame strobe (vsync-derived, same clock domain); its rising edge is the frame tick.
- start, input, 1: level; sampled in IDLE and DEAD.
- collision, input, 1: registered collision flag from the collision detector.
- pipe_x, output, 10: pipe horizontal centre.
- pipe_y, output, 10: gap vertical centre.
- score, output, 8: pipes passed, saturating.
- score_pulse, output, 1: one-cycle strobe per pipe passed.
- running, output, 1: high in RUN.

Behaviour:
- Reset values:
  - pipe_x=SPAWN_X, pipe_y=IDLE_Y, score=0, score_pulse=0, running=0.
  - State=IDLE; LFSR=8'hA5; frame edge register=0.
- Reset wins over every other input, in every state.
- Frame tick:
  - tick = frame_clk & ~frame_clk_q, with frame_clk_q registered every Clk.
  - Exactly one tick per rising edge.
  - Held-high frame_clk produces no further ticks.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every Clk cycle in all states.
  - Never reaches 0 from the nonzero seed.
- State machine (IDLE, RUN, DEAD):
  - IDLE:
    - Outputs held at their reset values, except the LFSR keeps running.
    - start=1 -> RUN next cycle; score cleared to 0 on this transition.
  - RUN (running=1):
    - collision=1 -> DEAD next cycle.
    - A tick in the same cycle as collision is ignored: no movement, no score.
  - DEAD:
    - pipe_x and pipe_y frozen at their last values; score held.
    - start=1 -> IDLE next cycle; pipe_x and pipe_y return to SPAWN_X and IDLE_Y.
    - An IDLE->RUN transition requires start in a later cycle, so holding start takes two transitions.
- Motion on a tick in RUN with collision=0:
  - If pipe_x <= SPEED: respawn. pipe_x <= SPAWN_X; pipe_y <= GAP_Y_MIN + {2'b00, lfsr}, using the LFSR value in that cycle.
  - Else: pipe_x <= pipe_x - SPEED. Unsigned 10-bit arithmetic; no underflow is possible by construction.
- Scoring:
  - When a move takes pipe_x from > SCORE_X to <= SCORE_X, score_pulse=1 for exactly the next cycle.
  - score increments, saturating at 255; score_pulse still fires at 255.
  - Respawn never coincides with a score crossing, given SCORE_X > SPEED.
- Outputs change only in the cycle after a tick or a state transition.
- Latency: tick-to-pipe_x update is 1 cycle.
- start while in RUN is ignored.
- collision while in IDLE or DEAD is ignored.
- Parameter constraints: GAP_Y_MIN + 255 <= 1023; SPAWN_X <= 1023; SPEED >= 1.

Test Plan:
- Reset, then start=1 for 1 cycle -> running=1, pipe_x=700, pipe_y=240, score=0. One frame_clk rising edge -> pipe_x=698 one cycle later. frame_clk held high 10 cycles -> no further change.
- From pipe_x=266, two ticks -> pipe_x 264 after the first; score_pulse high exactly one cycle; score 0->1. Second tick -> pipe_x=262, no pulse.
- Pipe_x stepped to 2, then one tick -> pipe_x=700 and pipe_y = 120 + LFSR value at that cycle; pipe_y stays within 120..375 over 300 respawns.
- In RUN, assert collision in the same cycle as a tick -> pipe_x unchanged, running=0 next cycle. Further ticks leave pipe_x and pipe_y frozen. start -> IDLE with pipe_x=700, pipe_y=240; start again -> RUN with score=0.
- Preload score=255 via 255 crossings, then one more crossing -> score stays 255, score_pulse still fires.
- Assert Reset mid-RUN at pipe_x=400, score=7 -> next cycle state IDLE, pipe_x=700, pipe_y=240, score=0, LFSR=8'hA5.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller: moves one pipe leftward once per video frame, respawns it
// off-screen right with a pseudo-random gap centre, counts pipes passed and
// freezes all motion once the collision detector reports a hit.
module pipe_scroller #(
  parameter int SPEED     = 2,
  parameter int SPAWN_X   = 700,
  parameter int SCORE_X   = 264,
  parameter int GAP_Y_MIN = 120,
  parameter int IDLE_Y    = 240
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y,
  output logic [7:0] score,
  output logic       score_pulse,
  output logic       running
);

  localparam logic [9:0] SPEED_V     = 10'(SPEED);
  localparam logic [9:0] SPAWN_X_V   = 10'(SPAWN_X);
  localparam logic [9:0] SCORE_X_V   = 10'(SCORE_X);
  localparam logic [9:0] GAP_Y_MIN_V = 10'(GAP_Y_MIN);
  localparam logic [9:0] IDLE_Y_V    = 10'(IDLE_Y);
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       frame_clk_q;
  logic       tick;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [9:0] pipe_x_dec;
  logic [9:0] pipe_x_nxt;
  logic [9:0] pipe_y_nxt;
  logic [7:0] score_nxt;
  logic       score_pulse_nxt;

  // One tick per rising edge of the frame strobe; a held-high strobe is silent.
  assign tick = frame_clk & ~frame_clk_q;

  // Taps for x^8+x^6+x^5+x^4+1 with the sequence shifting toward the MSB.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Candidate position for a normal move; only used when pipe_x > SPEED.
  assign pipe_x_dec = pipe_x - SPEED_V;

  assign running = (state == RUN);

  // Frame edge register and free-running LFSR, active in every state.
  always_ff @(posedge Clk) begin
    // NOTE: clocked state is always assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    if (Reset) begin
      frame_clk_q <= 1'b0;
      lfsr        <= LFSR_SEED;
    end else begin
      frame_clk_q <= frame_clk;
      lfsr        <= {lfsr[6:0], lfsr_fb};
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pipe_x      <= SPAWN_X_V;
      pipe_y      <= IDLE_Y_V;
      score       <= '0;
      score_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      pipe_x      <= pipe_x_nxt;
      pipe_y      <= pipe_y_nxt;
      score       <= score_nxt;
      score_pulse <= score_pulse_nxt;
    end
  end

  // Next state, motion, respawn and scoring.
  always_comb begin
    // NOTE: every signal gets a hold/idle default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt       = state;
    pipe_x_nxt      = pipe_x;
    pipe_y_nxt      = pipe_y;
    score_nxt       = score;
    score_pulse_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        pipe_x_nxt = SPAWN_X_V;
        pipe_y_nxt = IDLE_Y_V;
        if (start) begin
          state_nxt = RUN;
          score_nxt = '0;
        end
      end

      RUN: begin
        if (collision) begin
          // A tick in the collision cycle is dropped: the scene freezes as-is.
          state_nxt = DEAD;
        end else if (tick) begin
          if (pipe_x <= SPEED_V) begin
            pipe_x_nxt = SPAWN_X_V;
            pipe_y_nxt = GAP_Y_MIN_V + {2'b00, lfsr};
          end else begin
            pipe_x_nxt = pipe_x_dec;
            if ((pipe_x > SCORE_X_V) && (pipe_x_dec <= SCORE_X_V)) begin
              score_pulse_nxt = 1'b1;
              if (score != 8'hFF) begin
                score_nxt = score + 8'd1;
              end
            end
          end
        end
      end

      DEAD: begin
        if (start) begin
          state_nxt  = IDLE;
          pipe_x_nxt = SPAWN_X_V;
          pipe_y_nxt = IDLE_Y_V;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: drives two pipe_scroller instances (default geometry and a
// short, fast geometry) from shared directed stimulus and checks both against
// a frame-level behavioural model every cycle, plus literal spot checks.
module tb_pipe_scroller;

  localparam int NI = 2;
  localparam int P_SPEED [NI] = '{2, 3};
  localparam int P_SPAWN [NI] = '{700, 30};
  localparam int P_SCORE [NI] = '{264, 10};
  localparam int P_GAPMIN[NI] = '{120, 100};
  localparam int P_IDLEY [NI] = '{240, 50};

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       start;
  logic       collision;
  logic [9:0] d_x     [NI];
  logic [9:0] d_y     [NI];
  logic [7:0] d_score [NI];
  logic       d_pulse [NI];
  logic       d_run   [NI];

  int checks   = 0;
  int failures = 0;

  pipe_scroller #(
    .SPEED(P_SPEED[0]), .SPAWN_X(P_SPAWN[0]), .SCORE_X(P_SCORE[0]),
    .GAP_Y_MIN(P_GAPMIN[0]), .IDLE_Y(P_IDLEY[0])
  ) u_dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .collision(collision), .pipe_x(d_x[0]), .pipe_y(d_y[0]),
    .score(d_score[0]), .score_pulse(d_pulse[0]), .running(d_run[0])
  );

  pipe_scroller #(
    .SPEED(P_SPEED[1]), .SPAWN_X(P_SPAWN[1]), .SCORE_X(P_SCORE[1]),
    .GAP_Y_MIN(P_GAPMIN[1]), .IDLE_Y(P_IDLEY[1])
  ) u_dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .collision(collision), .pipe_x(d_x[1]), .pipe_y(d_y[1]),
    .score(d_score[1]), .score_pulse(d_pulse[1]), .running(d_run[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s[%0d] at %0t: got=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  int         m_mode      [NI];
  int         m_x         [NI];
  int         m_y         [NI];
  int         m_score     [NI];
  int         m_prev_score[NI];
  bit         m_pulse     [NI];
  bit         m_fprev     [NI];
  bit         m_score_ok  [NI];
  bit         m_resp_evt  [NI];
  int         m_respawns  [NI];
  logic [7:0] m_lfsr      [NI];
  bit         m_live = 0;

  // Frame-level model: one update per clock using the inputs held over the edge.
  always @(posedge Clk) begin
    for (int i = 0; i < NI; i++) begin
      bit         tk;
      int         nx;
      logic [7:0] lf;
      m_resp_evt[i]   = 0;
      m_prev_score[i] = m_score[i];
      if (Reset) begin
        m_mode[i]     = M_IDLE;
        m_x[i]        = P_SPAWN[i];
        m_y[i]        = P_IDLEY[i];
        m_score[i]    = 0;
        m_pulse[i]    = 0;
        m_fprev[i]    = 0;
        m_lfsr[i]     = 8'hA5;
        m_score_ok[i] = 1;
        m_live        = 1;
      end else begin
        tk         = frame_clk && !m_fprev[i];
        m_fprev[i] = frame_clk;
        lf         = m_lfsr[i];
        m_pulse[i] = 0;
        if (m_mode[i] == M_IDLE) begin
          if (start) begin
            m_mode[i]     = M_RUN;
            m_score[i]    = 0;
            m_score_ok[i] = 1;
          end
        end else if (m_mode[i] == M_RUN) begin
          if (collision) begin
            m_mode[i] = M_DEAD;
          end else if (tk) begin
            if (m_x[i] <= P_SPEED[i]) begin
              m_x[i]        = P_SPAWN[i];
              m_y[i]        = P_GAPMIN[i] + int'(lf);
              m_resp_evt[i] = 1;
              m_respawns[i]++;
            end else begin
              nx = m_x[i] - P_SPEED[i];
              if (m_x[i] > P_SCORE[i] && nx <= P_SCORE[i]) begin
                m_pulse[i] = 1;
                if (m_score[i] < 255) m_score[i]++;
              end
              m_x[i] = nx;
            end
          end
        end else begin
          if (start) begin
            m_mode[i]     = M_IDLE;
            m_x[i]        = P_SPAWN[i];
            m_y[i]        = P_IDLEY[i];
            m_score_ok[i] = 0;  // displayed score in IDLE after a game is not pinned
          end
        end
        m_lfsr[i] = lfsr_step(lf);
      end
    end
  end

  int sat_seen[NI];

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_live) begin
      for (int i = 0; i < NI; i++) begin
        check("pipe_x", i, int'(d_x[i]), m_x[i]);
        check("pipe_y", i, int'(d_y[i]), m_y[i]);
        check("score_pulse", i, int'(d_pulse[i]), int'(m_pulse[i]));
        check("running", i, int'(d_run[i]), (m_mode[i] == M_RUN) ? 1 : 0);
        if (m_score_ok[i] || m_mode[i] != M_IDLE)
          check("score", i, int'(d_score[i]), m_score[i]);
        if (m_resp_evt[i])
          check("pipe_y_range", i,
                (int'(d_y[i]) >= P_GAPMIN[i] && int'(d_y[i]) <= P_GAPMIN[i] + 255) ? 1 : 0, 1);
        if (m_pulse[i] && m_prev_score[i] == 255 && d_pulse[i])
          sat_seen[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    cyc(1);
    frame_clk = 1'b0;
    cyc(1);
  endtask

  int n;
  int save_x;
  int save_y;

  initial begin
    Reset = 1'b1; start = 1'b0; collision = 1'b0; frame_clk = 1'b0;
    cyc(3);
    check("rst_pipe_x", 0, int'(d_x[0]), 700);
    check("rst_pipe_y", 0, int'(d_y[0]), 240);
    check("rst_score", 0, int'(d_score[0]), 0);
    check("rst_pulse", 0, int'(d_pulse[0]), 0);
    check("rst_running", 0, int'(d_run[0]), 0);
    check("model_seed", 0, int'(m_lfsr[0]), 8'hA5);
    Reset = 1'b0;
    cyc(2);

    // Start the game.
    start = 1'b1; cyc(1); start = 1'b0;
    check("start_running", 0, int'(d_run[0]), 1);
    check("start_x", 0, int'(d_x[0]), 700);
    check("start_y", 0, int'(d_y[0]), 240);
    check("start_score", 0, int'(d_score[0]), 0);

    // One rising edge moves the pipe one step; a held-high strobe does nothing more.
    frame_clk = 1'b1; cyc(1);
    check("tick_x", 0, int'(d_x[0]), 698);
    cyc(10);
    check("held_high_x", 0, int'(d_x[0]), 698);
    frame_clk = 1'b0; cyc(1);

    // Walk to the scoring line.
    n = 0;
    while (m_x[0] != 266 && n < 400) begin tick(); n++; end
    check("reach_266", 0, int'(d_x[0]), 266);
    check("pre_cross_score", 0, int'(d_score[0]), 0);
    frame_clk = 1'b1; cyc(1);
    check("cross_x", 0, int'(d_x[0]), 264);
    check("cross_pulse", 0, int'(d_pulse[0]), 1);
    check("cross_score", 0, int'(d_score[0]), 1);
    frame_clk = 1'b0; cyc(1);
    check("pulse_one_cycle", 0, int'(d_pulse[0]), 0);
    frame_clk = 1'b1; cyc(1);
    check("post_cross_x", 0, int'(d_x[0]), 262);
    check("post_cross_pulse", 0, int'(d_pulse[0]), 0);
    frame_clk = 1'b0; cyc(1);

    // Walk down to x=2, then respawn.
    n = 0;
    while (m_x[0] != 2 && n < 400) begin tick(); n++; end
    check("reach_2", 0, int'(d_x[0]), 2);
    frame_clk = 1'b1; cyc(1);
    check("respawn_x", 0, int'(d_x[0]), 700);
    check("respawn_y", 0, int'(d_y[0]), m_y[0]);
    check("respawn_y_range", 0, (d_y[0] >= 10'd120 && d_y[0] <= 10'd375) ? 1 : 0, 1);
    frame_clk = 1'b0; cyc(1);

    // Long run: the short-geometry instance saturates its score and respawns 300+ times.
    n = 0;
    while ((m_respawns[1] < 300 || sat_seen[1] == 0) && n < 4000) begin tick(); n++; end
    check("bulk_in_budget", 1, (n < 4000) ? 1 : 0, 1);
    check("sat_score", 1, int'(d_score[1]), 255);
    check("sat_pulse_seen", 1, (sat_seen[1] > 0) ? 1 : 0, 1);
    check("respawns_300", 1, (m_respawns[1] >= 300) ? 1 : 0, 1);

    // Collision coinciding with a tick: no move, game over.
    save_x = m_x[0]; save_y = m_y[0];
    frame_clk = 1'b1; collision = 1'b1; cyc(1);
    check("coll_running", 0, int'(d_run[0]), 0);
    check("coll_x_frozen", 0, int'(d_x[0]), save_x);
    frame_clk = 1'b0; collision = 1'b0; cyc(1);
    repeat (3) tick();
    check("dead_x_frozen", 0, int'(d_x[0]), save_x);
    check("dead_y_frozen", 0, int'(d_y[0]), save_y);
    start = 1'b1; cyc(1); start = 1'b0;
    check("to_idle_x", 0, int'(d_x[0]), 700);
    check("to_idle_y", 0, int'(d_y[0]), 240);
    check("to_idle_running", 0, int'(d_run[0]), 0);
    collision = 1'b1; cyc(1); collision = 1'b0;
    check("idle_ignores_coll", 0, int'(d_run[0]), 0);
    start = 1'b1; cyc(1); start = 1'b0;
    check("restart_running", 0, int'(d_run[0]), 1);
    check("restart_score", 0, int'(d_score[0]), 0);

    // Reset mid-game at pipe_x=400, score=7.
    n = 0;
    while (!(m_score[0] == 7 && m_x[0] == 400) && n < 5000) begin tick(); n++; end
    check("mid_x", 0, int'(d_x[0]), 400);
    check("mid_score", 0, int'(d_score[0]), 7);
    Reset = 1'b1; cyc(1);
    check("mid_rst_x", 0, int'(d_x[0]), 700);
    check("mid_rst_y", 0, int'(d_y[0]), 240);
    check("mid_rst_score", 0, int'(d_score[0]), 0);
    check("mid_rst_running", 0, int'(d_run[0]), 0);
    check("mid_rst_seed", 0, int'(m_lfsr[0]), 8'hA5);
    Reset = 1'b0; cyc(3);
    check("post_rst_idle", 0, int'(d_run[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
